// File: rtl/mul16u_sched_pkg.sv
// mul16u_sched_pkg: shared constants, parameter defaults and pipeline stage record
package mul16u_sched_pkg;
  localparam int OP_W = 16;
  localparam int PROD_W = 32;
  localparam int NREQ_DEF = 4;
  localparam int TRUNC_BITS_DEF = 10;
  localparam int LAT_DEF = 2;
  localparam int ID_W = 8;
  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic [PROD_W-1:0] product;
  } stage_t;
endpackage

// File: rtl/mul16u_trunc_unit.sv
// mul16u_trunc_unit: operand truncation and LAT-1 register stages of multiply, held when en_i is low
module mul16u_trunc_unit
  import mul16u_sched_pkg::*;
#(
  parameter int TRUNC_BITS = TRUNC_BITS_DEF,
  parameter int LAT = LAT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic            valid_i,
  input  logic [ID_W-1:0] id_i,
  input  logic [OP_W-1:0] a_i,
  input  logic [OP_W-1:0] b_i,
  input  logic            exact_i,
  output stage_t          stage_o,
  output logic            busy_o
);
  localparam logic [OP_W-1:0] MASK = {OP_W{1'b1}} << TRUNC_BITS;
  logic [OP_W-1:0] am, bm;
  stage_t s_in;
  // mask operand LSBs in approximate mode and form the full-width product
  always_comb begin
    am = exact_i ? a_i : a_i & MASK;
    bm = exact_i ? b_i : b_i & MASK;
    s_in.valid = valid_i;
    s_in.id = id_i;
    s_in.product = {{OP_W{1'b0}}, am} * {{OP_W{1'b0}}, bm};
  end
  if (LAT == 1) begin : g_comb
    assign stage_o = s_in;
    assign busy_o = 1'b0;
  end else begin : g_pipe
    stage_t st_q [LAT-1];
    // shift the stage records forward only when the output side can advance
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < LAT-1; i++) st_q[i] <= '0;
      end else if (en_i) begin
        st_q[0] <= s_in;
        for (int i = 1; i < LAT-1; i++) st_q[i] <= st_q[i-1];
      end
    end
    // any valid stage means work is in flight
    always_comb begin
      busy_o = 1'b0;
      for (int i = 0; i < LAT-1; i++) busy_o = busy_o | st_q[i].valid;
    end
    assign stage_o = st_q[LAT-2];
  end
endmodule

// File: rtl/mul16u_trunc_sched.sv
// mul16u_trunc_sched: round-robin shared 16x16 multiplier with per-request truncation and output register
module mul16u_trunc_sched
  import mul16u_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int TRUNC_BITS = TRUNC_BITS_DEF,
  parameter int LAT = LAT_DEF,
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OP_W-1:0] req_a,
  input  logic [NREQ*OP_W-1:0] req_b,
  input  logic [NREQ-1:0]      req_exact,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [PROD_W-1:0]    rsp_z,
  output logic [IW-1:0]        rsp_id,
  output logic                 busy
);
  logic [IW-1:0] ptr_q, ptr_d, gidx, j;
  logic [IW:0] s;
  logic found, advance, fire, unit_busy, exact_sel, unused_id;
  logic [OP_W-1:0] a_sel, b_sel;
  stage_t unit_out, out_q;
  assign advance = !out_q.valid || rsp_ready;
  // search upward from ptr with wrap, grant the first valid requester, select its operands
  always_comb begin
    found = 1'b0;
    gidx = '0;
    s = '0;
    j = '0;
    for (int k = 0; k < NREQ; k++) begin
      s = {1'b0, ptr_q} + (IW+1)'(k);
      j = s >= (IW+1)'(NREQ) ? IW'(s - (IW+1)'(NREQ)) : IW'(s);
      if (!found && req_valid[j]) begin
        found = 1'b1;
        gidx = j;
      end
    end
    a_sel = '0;
    b_sel = '0;
    exact_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gidx == IW'(i)) begin
        a_sel = req_a[i*OP_W +: OP_W];
        b_sel = req_b[i*OP_W +: OP_W];
        exact_sel = req_exact[i];
      end
    end
    fire = found && advance && !rst;
    req_ready = fire ? NREQ'(1) << gidx : '0;
    ptr_d = fire ? (gidx == IW'(NREQ-1) ? '0 : gidx + 1'b1) : ptr_q;
  end
  mul16u_trunc_unit #(.TRUNC_BITS(TRUNC_BITS), .LAT(LAT)) u_unit (
    .clk(clk),
    .rst(rst),
    .en_i(advance),
    .valid_i(fire),
    .id_i(ID_W'(gidx)),
    .a_i(a_sel),
    .b_i(b_sel),
    .exact_i(exact_sel),
    .stage_o(unit_out),
    .busy_o(unit_busy)
  );
  // round-robin pointer moves past the requester just served
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
  // output register holds its result until downstream accepts it
  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else if (advance) out_q <= unit_out;
  end
  assign rsp_valid = out_q.valid;
  assign rsp_z = out_q.product;
  assign rsp_id = out_q.id[IW-1:0];
  assign busy = out_q.valid | unit_busy;
  assign unused_id = ^out_q.id[ID_W-1:IW];
endmodule
